// File: rtl/dco_scheduler_pkg.sv
// Shared types and defaults for the DCO time-sharing scheduler.
package dco_sched_pkg;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StLoad = 2'd1,
      StRun  = 2'd2
   } state_e;

   localparam int unsigned DefaultN     = 8;
   localparam int unsigned DefaultReq   = 4;
   localparam int unsigned DefaultBurst = 4;

endpackage

// File: rtl/dco_scheduler_if.sv
// Requester/DCO-side bundle of the scheduler: master = requesters, slave = scheduler.
interface dco_scheduler_if #(
   parameter int unsigned N   = 8,
   parameter int unsigned REQ = 4
);
   logic [REQ-1:0]   req;
   logic [REQ*N-1:0] cfg_max;
   logic [REQ*N-1:0] cfg_duty;
   logic [REQ-1:0]   gnt;
   logic [N-1:0]     dco_max;
   logic [N-1:0]     dco_duty;
   logic             dco_rst;
   logic [REQ-1:0]   done;
   logic             busy;

   modport master (
      output req, cfg_max, cfg_duty,
      input  gnt, dco_max, dco_duty, dco_rst, done, busy
   );

   modport slave (
      input  req, cfg_max, cfg_duty,
      output gnt, dco_max, dco_duty, dco_rst, done, busy
   );
endinterface

// File: rtl/dco_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first set request at index >= ptr, wrapping.
module rr_arbiter #(
   parameter int unsigned REQ = 4,
   localparam int unsigned IW = $clog2(REQ)
) (
   input  logic [REQ-1:0] req,
   input  logic [IW-1:0]  ptr,
   output logic [REQ-1:0] win,
   output logic [IW-1:0]  win_idx,
   output logic           any
);

   logic          found;
   logic [IW-1:0] k;

   always_comb begin
      win     = '0;
      win_idx = '0;
      found   = 1'b0;
      k       = '0;
      for (int unsigned i = 0; i < REQ; i++) begin
         k = IW'((32'(ptr) + i) % REQ);
         if (!found && req[k]) begin
            found   = 1'b1;
            win[k]  = 1'b1;
            win_idx = k;
         end
      end
   end

   assign any = |req;

endmodule

// File: rtl/dco_scheduler.sv
// Time-shares one DCO among REQ requesters, granting BURST full periods per round-robin win.
module dco_scheduler
   import dco_sched_pkg::*;
#(
   parameter int unsigned N     = DefaultN,
   parameter int unsigned REQ   = DefaultReq,
   parameter int unsigned BURST = DefaultBurst
) (
   input logic            clk,
   input logic            reset,
   dco_scheduler_if.slave bus
);

   localparam int unsigned IW = $clog2(REQ);
   localparam int unsigned PW = $clog2(BURST + 1);
   localparam logic [PW-1:0] PcLast = PW'(BURST - 1);

   state_e         state_q, state_d;
   logic [IW-1:0]  ptr_q, ptr_d;
   logic [IW-1:0]  w_q, w_d;
   logic [N-1:0]   ph_q, ph_d;
   logic [PW-1:0]  pc_q, pc_d;
   logic [REQ-1:0] gnt_q, gnt_d;
   logic [N-1:0]   max_q, max_d;
   logic [N-1:0]   duty_q, duty_d;
   logic           rst_q, rst_d;
   logic [REQ-1:0] done_q, done_d;
   logic           busy_q, busy_d;

   logic [REQ-1:0] win;
   logic [IW-1:0]  win_idx;
   logic           any;
   logic [N-1:0]   cfg_max_sel, cfg_duty_sel;
   logic           period_end, burst_end, released, load_now;

   rr_arbiter #(
      .REQ (REQ)
   ) u_arb (
      .req     (bus.req),
      .ptr     (ptr_q),
      .win     (win),
      .win_idx (win_idx),
      .any     (any)
   );

   always_comb begin
      cfg_max_sel  = '0;
      cfg_duty_sel = '0;
      for (int i = 0; i < REQ; i++) begin
         cfg_max_sel  |= bus.cfg_max[i*N +: N] & {N{win[i]}};
         cfg_duty_sel |= bus.cfg_duty[i*N +: N] & {N{win[i]}};
      end
   end

   assign period_end = (ph_q == max_q);
   assign burst_end  = period_end && (pc_q == PcLast);
   assign released   = period_end && !bus.req[w_q];

   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      w_d      = w_q;
      ph_d     = ph_q;
      pc_d     = pc_q;
      gnt_d    = gnt_q;
      max_d    = max_q;
      duty_d   = duty_q;
      rst_d    = rst_q;
      busy_d   = busy_q;
      done_d   = '0;
      load_now = 1'b0;

      unique case (state_q)
         StIdle: load_now = any;
         StLoad: begin
            state_d = StRun;
            rst_d   = 1'b0;
            ph_d    = '0;
            pc_d    = '0;
         end
         StRun: begin
            if (burst_end || released) begin
               if (any) begin
                  load_now = 1'b1;
               end else begin
                  state_d = StIdle;
                  gnt_d   = '0;
                  rst_d   = 1'b1;
                  busy_d  = 1'b0;
               end
            end else if (period_end) begin
               ph_d = '0;
               pc_d = pc_q + 1'b1;
            end else begin
               ph_d = ph_q + 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase

      if (load_now) begin
         state_d = StLoad;
         w_d     = win_idx;
         gnt_d   = win;
         max_d   = cfg_max_sel;
         duty_d  = cfg_duty_sel;
         rst_d   = 1'b1;
         busy_d  = 1'b1;
         ph_d    = '0;
         pc_d    = '0;
         ptr_d   = (win_idx == IW'(REQ - 1)) ? '0 : win_idx + 1'b1;
      end

      // Look ahead one cycle so the registered done lands on the last RUN cycle.
      if (state_d == StRun && ph_d == max_q && pc_d == PcLast) begin
         done_d = gnt_q;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;
         ptr_q   <= '0;
         w_q     <= '0;
         ph_q    <= '0;
         pc_q    <= '0;
         gnt_q   <= '0;
         max_q   <= '0;
         duty_q  <= '0;
         rst_q   <= 1'b1;
         done_q  <= '0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         w_q     <= w_d;
         ph_q    <= ph_d;
         pc_q    <= pc_d;
         gnt_q   <= gnt_d;
         max_q   <= max_d;
         duty_q  <= duty_d;
         rst_q   <= rst_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
      end
   end

   assign bus.gnt      = gnt_q;
   assign bus.dco_max  = max_q;
   assign bus.dco_duty = duty_q;
   assign bus.dco_rst  = rst_q;
   assign bus.done     = done_q;
   assign bus.busy     = busy_q;

endmodule

// File: tb/tb_dco_scheduler.sv
// Directed bench for dco_scheduler: three instances cover BURST = 4, 2 and 1.
module tb_dco_scheduler;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   dco_scheduler_if #(.N(8), .REQ(4)) if4 ();
   dco_scheduler_if #(.N(8), .REQ(4)) if2 ();
   dco_scheduler_if #(.N(8), .REQ(4)) if1 ();

   dco_scheduler #(.N(8), .REQ(4), .BURST(4)) u_b4 (.clk(clk), .reset(reset), .bus(if4));
   dco_scheduler #(.N(8), .REQ(4), .BURST(2)) u_b2 (.clk(clk), .reset(reset), .bus(if2));
   dco_scheduler #(.N(8), .REQ(4), .BURST(1)) u_b1 (.clk(clk), .reset(reset), .bus(if1));

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   int          cnt, done_at, done_n;
   logic [3:0]  done_v;
   int          g;

   initial begin
      reset = 1'b1;
      if4.req = '0; if4.cfg_max = '0; if4.cfg_duty = '0;
      if2.req = '0; if2.cfg_max = '0; if2.cfg_duty = '0;
      if1.req = '0; if1.cfg_max = '0; if1.cfg_duty = '0;
      tick();
      tick();
      check("rst_gnt",  32'(if4.gnt), 32'h0);
      check("rst_max",  32'(if4.dco_max), 32'h0);
      check("rst_duty", 32'(if4.dco_duty), 32'h0);
      check("rst_dcor", 32'(if4.dco_rst), 32'h1);
      check("rst_done", 32'(if4.done), 32'h0);
      check("rst_busy", 32'(if4.busy), 32'h0);
      reset = 1'b0;
      tick();

      // Single request, BURST=4, period 4 clocks
      if4.cfg_max[1*8 +: 8]  = 8'd3;
      if4.cfg_duty[1*8 +: 8] = 8'd1;
      if4.req = 4'b0010;
      tick();
      check("t1_load_gnt",  32'(if4.gnt), 32'h2);
      check("t1_load_max",  32'(if4.dco_max), 32'h3);
      check("t1_load_duty", 32'(if4.dco_duty), 32'h1);
      check("t1_load_dcor", 32'(if4.dco_rst), 32'h1);
      check("t1_load_busy", 32'(if4.busy), 32'h1);
      cnt = 0; done_at = 0; done_n = 0; done_v = '0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (if4.dco_rst == 1'b0) cnt++;
         if (if4.done != '0) begin
            done_n++;
            done_at = cnt;
            done_v  = if4.done;
            if4.req = '0;
         end
         if (if4.dco_rst && cnt > 0) break;
      end
      check("t1_run_len",   32'(cnt), 32'd16);
      check("t1_done_at",   32'(done_at), 32'd16);
      check("t1_done_n",    32'(done_n), 32'd1);
      check("t1_done_v",    32'(done_v), 32'h2);
      check("t1_idle_gnt",  32'(if4.gnt), 32'h0);
      check("t1_idle_busy", 32'(if4.busy), 32'h0);
      check("t1_idle_dcor", 32'(if4.dco_rst), 32'h1);

      // Round robin, BURST=2, period 1 clock: LOAD + 2 RUN per grant
      if2.req = 4'b1111;
      for (int k = 1; k <= 15; k++) begin
         tick();
         g = ((k - 1) / 3) % 4;
         check($sformatf("t2_gnt_%0d", k), 32'(if2.gnt), 32'(1 << g));
         check($sformatf("t2_dcor_%0d", k), 32'(if2.dco_rst), ((k - 1) % 3 == 0) ? 32'h1 : 32'h0);
         check($sformatf("t2_done_%0d", k), 32'(if2.done),
               ((k - 1) % 3 == 2) ? 32'(1 << g) : 32'h0);
      end
      if2.req = '0;

      // Early release of requester 2, requester 3 pending
      pulse_reset();
      if4.cfg_max[2*8 +: 8] = 8'd7;
      if4.cfg_max[3*8 +: 8] = 8'd2;
      if4.req = 4'b0100;
      tick();
      check("t3_load_gnt", 32'(if4.gnt), 32'h4);
      check("t3_load_max", 32'(if4.dco_max), 32'h7);
      for (int i = 1; i <= 5; i++) begin
         tick();
         if (i == 2) if4.req = 4'b1100;
         check($sformatf("t3_run_dcor_%0d", i), 32'(if4.dco_rst), 32'h0);
      end
      if4.req = 4'b1000;
      for (int i = 6; i <= 8; i++) begin
         tick();
         check($sformatf("t3_hold_gnt_%0d", i), 32'(if4.gnt), 32'h4);
         check($sformatf("t3_hold_dcor_%0d", i), 32'(if4.dco_rst), 32'h0);
         check($sformatf("t3_hold_done_%0d", i), 32'(if4.done), 32'h0);
      end
      tick();
      check("t3_next_gnt",  32'(if4.gnt), 32'h8);
      check("t3_next_dcor", 32'(if4.dco_rst), 32'h1);
      check("t3_next_max",  32'(if4.dco_max), 32'h2);
      check("t3_next_done", 32'(if4.done), 32'h0);

      // Config change during RUN is ignored until the next LOAD
      pulse_reset();
      if4.cfg_max[0*8 +: 8]  = 8'd5;
      if4.cfg_duty[0*8 +: 8] = 8'd2;
      if4.req = 4'b0001;
      tick();
      check("t4_load_max", 32'(if4.dco_max), 32'h5);
      for (int i = 1; i <= 24; i++) begin
         tick();
         if (i == 2) if4.cfg_max[0*8 +: 8] = 8'd9;
         if (i == 10) check("t4_run_max", 32'(if4.dco_max), 32'h5);
         if (i == 23) check("t4_pre_done", 32'(if4.done), 32'h0);
         if (i == 24) check("t4_done", 32'(if4.done), 32'h1);
      end
      tick();
      check("t4_reload_gnt",  32'(if4.gnt), 32'h1);
      check("t4_reload_dcor", 32'(if4.dco_rst), 32'h1);
      check("t4_reload_max",  32'(if4.dco_max), 32'h9);

      // Asynchronous reset mid-burst
      tick();
      tick();
      tick();
      #2;
      reset = 1'b1;
      #1;
      check("t5_gnt",  32'(if4.gnt), 32'h0);
      check("t5_dcor", 32'(if4.dco_rst), 32'h1);
      check("t5_busy", 32'(if4.busy), 32'h0);
      check("t5_done", 32'(if4.done), 32'h0);
      check("t5_max",  32'(if4.dco_max), 32'h0);
      if4.req = 4'b1010;
      tick();
      tick();
      reset = 1'b0;
      tick();
      check("t5_rearb_gnt", 32'(if4.gnt), 32'h2);
      if4.req = '0;

      // Extreme settings, BURST=1: one 256-clock period
      if1.cfg_max[0*8 +: 8]  = 8'd255;
      if1.cfg_duty[0*8 +: 8] = 8'd255;
      if1.req = 4'b0001;
      tick();
      check("t6_load_max",  32'(if1.dco_max), 32'hff);
      check("t6_load_duty", 32'(if1.dco_duty), 32'hff);
      cnt = 0; done_at = 0; done_n = 0; done_v = '0;
      for (int i = 0; i < 300; i++) begin
         tick();
         if (if1.dco_rst == 1'b0) cnt++;
         if (if1.done != '0) begin
            done_n++;
            done_at = cnt;
            done_v  = if1.done;
            if1.req = '0;
         end
         if (if1.dco_rst && cnt > 0) break;
      end
      check("t6_run_len",   32'(cnt), 32'd256);
      check("t6_done_at",   32'(done_at), 32'd256);
      check("t6_done_n",    32'(done_n), 32'd1);
      check("t6_done_v",    32'(done_v), 32'h1);
      check("t6_idle_busy", 32'(if1.busy), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/dco_scheduler.md
# dco_scheduler

Time-shares one `stdDCON` oscillator among REQ requesters (e.g. resonator channels of the resonate-and-fire array), each supplying its own period/duty setting. A round-robin arbiter grants the DCO for BURST full oscillation periods. The scheduler drives the DCO's `maxVal`/`duty`/`reset` inputs and reports grant and burst completion back to the requesters. It sits directly in front of the `stdDCON` instance and shares its `clk`.

## Interface
- `N`, 8: DCO control width; must equal the driven `stdDCON` N.
- `REQ`, 4: number of requesters, ≥2.
- `BURST`, 4: DCO periods per grant, ≥1.

- `clk`  in  1  system clock; same clock as the DCO.
- `reset`  in  1  one clock; reset is asynchronous and active-high.
- `req`  in  REQ  level request per requester.
- `cfg_max`  in  REQ*N  per-requester period setting; slice i = bits [i*N +: N].
- `cfg_duty`  in  REQ*N  per-requester duty setting; same slicing.
- `gnt`  out  REQ  one-hot registered grant; all-zero when idle.
- `dco_max`  out  N  to DCO `maxVal`.
- `dco_duty`  out  N  to DCO `duty`.
- `dco_rst`  out  1  to DCO `reset`; restarts the DCO phase.
- `done`  out  REQ  one-cycle pulse on bit i when grant i completes all BURST periods.
- `busy`  out  1  high in LOAD or RUN.

## Operation
- States: IDLE, LOAD, RUN.
- IDLE:
  - `dco_rst`=1, `gnt`=0.
  - Any `req` bit set → LOAD with winner w, picked by round-robin from pointer `ptr`: the first set bit at index ≥ptr, wrapping.
- LOAD, exactly 1 cycle:
  - Latch `cfg_max[w]`/`cfg_duty[w]` into `dco_max`/`dco_duty`.
  - `gnt`=onehot(w), `dco_rst`=1.
  - Clear phase counter `ph` (N bits) and period counter `pc` ($clog2(BURST+1) bits).
  - Set `ptr` = (w+1) mod REQ.
  - Next state RUN.
- RUN:
  - `dco_rst`=0.
  - `ph` counts 0..`dco_max` and wraps to 0. This mirrors the DCO, so one period = `dco_max`+1 clocks.
  - At `ph`==`dco_max`: `pc` increments.
  - When `pc`==BURST-1 and `ph`==`dco_max`: pulse `done[w]`, then next state is LOAD if any `req` bit is set, otherwise IDLE.
- Config is sampled only in LOAD; changes to `cfg_*` during RUN are ignored.
- Early release: if `req[w]` drops during RUN, the grant ends at the next period boundary (`ph`==`dco_max`) with no `done` pulse. Next state follows the same rule as burst end.
- `dco_max`=0: period = 1 clock; the burst lasts BURST clocks.
- `duty` ≥ `max`: passed through unchanged. The DCO then outputs `clk`; scheduler timing is unaffected.
- A requester asserting while another holds the grant waits; it is never preempted.
- After one burst, the same requester regains the grant only if no other request is pending at arbitration time.

## Timing
- Reset values:
  - `gnt`=0, `dco_max`=0, `dco_duty`=0, `dco_rst`=1, `done`=0, `busy`=0.
  - `ptr`=0, state IDLE, `ph`=0, `pc`=0.
- `req` first high in IDLE at cycle t → LOAD at t+1 (`gnt`, `dco_*`, `busy` valid) → RUN at t+2, when the DCO leaves reset.
- Burst in RUN lasts exactly BURST*(`dco_max`+1) cycles. `done` is high on the last RUN cycle.
- Back-to-back grants are separated by exactly one LOAD cycle (`dco_rst`=1, `gnt` switched).
- `done` and the state change share an edge. `gnt` changes one cycle after `done`.
- All outputs are registered; no combinational path from `req`/`cfg_*` to outputs.
- Mid-operation `reset`: all outputs return to reset values immediately (asynchronously). No `done` pulse. Arbitration restarts from `ptr`=0.

## Structure
- Package `dco_sched_pkg`:
  - State encodings IDLE=2'd0, LOAD=2'd1, RUN=2'd2.
  - Default BURST/REQ constants.
- Sub-module `rr_arbiter`:
  - Inputs: `req`, `ptr`.
  - Outputs: one-hot `win`, `win_idx`, `any`.
  - Purely combinational; instantiated once. `ptr` stays in `dco_scheduler`.
- Top: FSM, `ph`/`pc` counters, config mux and registers.

## Test plan
- Single request: REQ=4, BURST=4, `req`=4'b0010, `cfg_max[1]`=3, `cfg_duty[1]`=1 → `gnt`=0010 one cycle after `req`. `dco_rst` low for exactly 16 cycles. `done[1]` pulses on the 16th. Returns to IDLE with `dco_rst`=1.
- Round-robin: `req`=4'b1111 held, all `cfg_max`=0, BURST=2 → grant order 0,1,2,3,0. Each grant is 1 LOAD cycle + 2 RUN cycles.
- Early release: `req[2]` drops 5 cycles into RUN with `cfg_max`=7 → grant ends at `ph`==7 of the current period. No `done`. Next pending requester is loaded.
- Config change ignored: `cfg_max[0]` changes 5→9 during RUN → `dco_max` stays 5 until the next LOAD.
- Async reset mid-burst: `reset` asserted at an arbitrary RUN cycle → same-cycle `gnt`=0, `dco_rst`=1, `busy`=0. After release with `req`=4'b1010, requester 1 wins (`ptr`=0).
- Edge settings: `cfg_max`=255, `cfg_duty`=255, BURST=1 → burst lasts 256 cycles. `ph` wraps correctly. `dco_duty`=255 passed through.
